// File: rtl/i2s_tdm_rx_if.sv
// Serial audio receiver bus: serial-side inputs and the published frame.
interface i2s_tdm_rx_if #(
  parameter int unsigned DATA_BIT = 16,
  parameter int unsigned CHANNELS = 2
);
  logic                         i_enable;
  logic                         i_sclk_rise;
  logic                         i_lrclk;
  logic                         i_sd;
  logic [CHANNELS*DATA_BIT-1:0] o_audio;
  logic                         o_valid;
  logic                         o_frame_err;

  modport master (
    output i_enable, i_sclk_rise, i_lrclk, i_sd,
    input  o_audio, o_valid, o_frame_err
  );

  modport slave (
    input  i_enable, i_sclk_rise, i_lrclk, i_sd,
    output o_audio, o_valid, o_frame_err
  );
endinterface

// File: rtl/i2s_tdm_rx.sv
// I2S / left-justified / TDM receiver: frame-sync-aligned deserialiser with
// frame-length checking and atomic frame publication.
module i2s_tdm_rx #(
  parameter int unsigned DATA_BIT = 16,
  parameter int unsigned SLOT_BIT = 32,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned MODE     = 0
) (
  input  logic        i_clk_12_288,
  input  logic        i_reset,
  i2s_tdm_rx_if.slave bus
);

  localparam int unsigned FRAME = CHANNELS * SLOT_BIT;
  localparam int unsigned BW    = (SLOT_BIT > 1) ? $clog2(SLOT_BIT) : 1;
  localparam int unsigned SW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PW    = $clog2(FRAME + 1);
  localparam int unsigned AW    = CHANNELS * DATA_BIT;

  typedef enum logic [1:0] {IDLE, RECEIVE, WAIT_SYNC} state_t;

  state_t          state, state_next;
  logic [BW-1:0]   bit_cnt;
  logic [SW-1:0]   slot_cnt;
  logic [PW-1:0]   pos;
  logic            lrclk_prev;
  logic            late_seen;
  logic [AW-1:0]   shift_q;
  logic [AW-1:0]   shift_sampled;
  logic [AW-1:0]   audio_q;
  logic            valid_q;
  logic            err_q;

  logic sync_edge;
  logic at_last;
  logic start;
  logic take;
  logic publish;
  logic err;
  logic late_set;

  assign sync_edge = bus.i_sclk_rise & lrclk_prev & ~bus.i_lrclk;
  assign at_last   = (pos == PW'(FRAME - 1));

  assign bus.o_audio     = audio_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_frame_err = err_q;

  // Shift registers with the current strobe's bit merged in; bits beyond DATA_BIT never match.
  for (genvar s = 0; s < CHANNELS; s++) begin : g_slot
    for (genvar b = 0; b < DATA_BIT; b++) begin : g_bit
      assign shift_sampled[s*DATA_BIT+b] =
        (slot_cnt == SW'(s) && bit_cnt == BW'(DATA_BIT - 1 - b)) ? bus.i_sd
                                                                 : shift_q[s*DATA_BIT+b];
    end
  end

  always_ff @(posedge i_clk_12_288 or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!bus.i_enable) begin
      state_next = IDLE;
    end else if (bus.i_sclk_rise) begin
      case (state)
        IDLE:      if (sync_edge) state_next = RECEIVE;
        RECEIVE:   if (!sync_edge && at_last) state_next = WAIT_SYNC;
        WAIT_SYNC: if (sync_edge) state_next = RECEIVE;
        default:   state_next = IDLE;
      endcase
    end
  end

  // In I2S mode the edge strobe carries the previous frame's last bit, so it
  // both publishes and restarts; any other edge inside RECEIVE is early.
  always_comb begin
    start    = 1'b0;
    take     = 1'b0;
    publish  = 1'b0;
    err      = 1'b0;
    late_set = 1'b0;
    if (bus.i_enable && bus.i_sclk_rise) begin
      case (state)
        IDLE: start = sync_edge;
        RECEIVE: begin
          if (sync_edge && !(MODE == 0 && at_last)) begin
            err   = 1'b1;
            start = 1'b1;
          end else begin
            take    = 1'b1;
            publish = at_last;
            start   = sync_edge;
          end
        end
        WAIT_SYNC: begin
          if (sync_edge) begin
            start = 1'b1;
          end else if (!late_seen) begin
            err      = 1'b1;
            late_set = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk_12_288 or posedge i_reset) begin
    if (i_reset) begin
      shift_q    <= '0;
      audio_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      bit_cnt    <= '0;
      slot_cnt   <= '0;
      pos        <= '0;
      lrclk_prev <= 1'b0;
      late_seen  <= 1'b0;
    end else if (!bus.i_enable) begin
      shift_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      bit_cnt    <= '0;
      slot_cnt   <= '0;
      pos        <= '0;
      lrclk_prev <= bus.i_lrclk;
      late_seen  <= 1'b0;
    end else begin
      valid_q <= publish;
      err_q   <= err;
      if (publish)         audio_q    <= shift_sampled;
      if (bus.i_sclk_rise) lrclk_prev <= bus.i_lrclk;
      if (late_set)        late_seen  <= 1'b1;
      if (start) begin
        late_seen <= 1'b0;
        slot_cnt  <= '0;
        shift_q   <= '0;
        if (MODE != 0) begin
          shift_q[DATA_BIT-1] <= bus.i_sd;
          bit_cnt             <= BW'(1);
          pos                 <= PW'(1);
        end else begin
          bit_cnt <= '0;
          pos     <= '0;
        end
      end else if (take) begin
        shift_q <= shift_sampled;
        pos     <= pos + 1'b1;
        if (bit_cnt == BW'(SLOT_BIT - 1)) begin
          bit_cnt  <= '0;
          slot_cnt <= (slot_cnt == SW'(CHANNELS - 1)) ? '0 : slot_cnt + 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule
